// File: rtl/fifo_pop_ctrl.sv
// Read-side FIFO drain controller: credit-gated pops into a skid buffer, valid/ready egress.
// Optional burst mode (FIFO_POP_CTRL_WATERMARK_EN) arms only above the almost-empty watermark.
module fifo_pop_ctrl #(
  parameter int DATA_SIZE = 8,
  parameter int BUF_DEPTH = 4,
  parameter int COUNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic                 fifo_almost_empty,
  input  logic                 fifo_error,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [COUNT_W-1:0]   pop_count,
  output logic                 err_flag,
  input  logic                 err_clear,
  output logic                 busy
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t               state, state_nxt;
  logic                 inflight;
  logic [OCC_W-1:0]     occ;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [DATA_SIZE-1:0] mem [BUF_DEPTH];
  logic [OCC_W:0]       used;
  logic                 push, pop, arm, disarm;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef FIFO_POP_CTRL_WATERMARK_EN
  assign arm    = enable && !fifo_empty && !fifo_almost_empty;
  assign disarm = !inflight && (!enable || fifo_empty);
`else
  logic unused_almost_empty;
  assign unused_almost_empty = fifo_almost_empty;
  assign arm    = enable;
  assign disarm = !inflight && !enable;
`endif

  // Credit counts the word already in flight so a push can never land on a full buffer.
  assign used      = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
  assign fifo_read = !reset && (state == ACTIVE) && enable && !fifo_empty &&
                     (used < (OCC_W+1)'(BUF_DEPTH));

  assign valid_out = (occ != '0);
  assign data_out  = mem[rd_ptr];
  assign pop       = valid_out && ready_in;
  assign push      = inflight;
  assign busy      = (state != IDLE) || inflight || valid_out;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arm)    state_nxt = ACTIVE;
      ACTIVE:  if (disarm) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      occ       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      pop_count <= '0;
      err_flag  <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_read;
      if (push) begin
        mem[wr_ptr] <= fifo_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr    <= ptr_inc(rd_ptr);
        pop_count <= pop_count + COUNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      if (fifo_error)     err_flag <= 1'b1;
      else if (err_clear) err_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// Bench for fifo_pop_ctrl: queue-based FIFO/skid-buffer reference model, directed and random phases.
module tb_fifo_pop_ctrl;
  logic        clk = 1'b0;
  logic        reset, enable, fifo_empty, fifo_almost_empty, fifo_error;
  logic        ready_in, err_clear;
  logic [7:0]  fifo_data;
  logic        fifo_read, valid_out, err_flag, busy;
  logic [7:0]  data_out;
  logic [15:0] pop_count;

  fifo_pop_ctrl #(.DATA_SIZE(8), .BUF_DEPTH(4), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_almost_empty(fifo_almost_empty), .fifo_error(fifo_error),
    .fifo_data(fifo_data), .fifo_read(fifo_read), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .pop_count(pop_count),
    .err_flag(err_flag), .err_clear(err_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: source FIFO contents, word in flight, skid buffer contents, counters.
  logic [7:0]  fifo_q[$];
  logic [7:0]  buf_q[$];
  bit          pending;
  logic [7:0]  pending_w;
  logic [15:0] m_count;
  bit          m_err;
  bit          chk_en;
  bit          last_rd;
  int          reads;

  task automatic upd_flags();
    fifo_empty        = (fifo_q.size() == 0);
    fifo_almost_empty = (fifo_q.size() <= 1);
  endtask

  task automatic fifo_push(input logic [7:0] w);
    fifo_q.push_back(w);
    upd_flags();
  endtask

  task automatic cycle();
    bit rd, xfer;
    @(negedge clk);
    rd = fifo_read;
    if (chk_en) begin
      check("valid_out", valid_out, buf_q.size() != 0);
      if (buf_q.size() != 0) check("data_out", data_out, buf_q[0]);
      check("pop_count", pop_count, m_count);
      check("err_flag", err_flag, m_err);
      if (buf_q.size() != 0 || pending) check("busy", busy, 1);
      if (reset || !enable) check("read_gate", rd, 0);
      if (rd) begin
        check("no_underflow", fifo_empty, 0);
        check("credit", (buf_q.size() + pending) < 4, 1);
      end
    end
    xfer = (buf_q.size() != 0) && ready_in && !reset;
    @(posedge clk);
    #1;
    if (reset) begin
      buf_q.delete();
      pending = 0;
      m_count = '0;
      m_err   = 0;
    end else begin
      if (xfer) begin
        void'(buf_q.pop_front());
        m_count++;
      end
      if (pending) buf_q.push_back(pending_w);
      pending = rd;
      if (rd && fifo_q.size() != 0) begin
        pending_w = fifo_q.pop_front();
        fifo_data = pending_w;
        upd_flags();
      end
      if (rd) reads++;
      if (fifo_error) m_err = 1;
      else if (err_clear) m_err = 0;
    end
    last_rd = rd;
  endtask

  task automatic do_reset();
    fifo_q.delete();
    upd_flags();
    reset = 1; enable = 0; ready_in = 0; fifo_error = 0; err_clear = 0;
    cycle();
    reset = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, first, lastc;
    reset = 1; enable = 0; ready_in = 0; fifo_error = 0; err_clear = 0;
    fifo_data = '0; pending = 0; m_count = '0; m_err = 0; chk_en = 0; reads = 0;
    upd_flags();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_count", pop_count, 0);
    check("rst_err", err_flag, 0);
    check("rst_busy", busy, 0);
    chk_en = 1;

    // Three preloaded words stream out back to back.
    do_reset();
    fifo_push(8'h11); fifo_push(8'h22); fifo_push(8'h33);
    enable = 1; ready_in = 1;
    r0 = reads; first = -1; lastc = -1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_rd) begin
        if (first < 0) first = i;
        lastc = i;
      end
    end
    check("t1_reads", reads - r0, 3);
    check("t1_consecutive", lastc - first, 2);
    check("t1_count", pop_count, 3);

    // Stalled downstream: only BUF_DEPTH pops, then drain the rest.
    do_reset();
    for (int i = 0; i < 8; i++) fifo_push(8'hA0 + 8'(i));
    enable = 1; ready_in = 0;
    r0 = reads;
    repeat (10) cycle();
    check("t2_reads_stalled", reads - r0, 4);
    check("t2_valid", valid_out, 1);
    check("t2_head", data_out, 8'hA0);
    ready_in = 1;
    repeat (14) cycle();
    check("t2_reads_total", reads - r0, 8);
    check("t2_count", pop_count, 8);

    // Enable dropped with a read in flight.
    do_reset();
    for (int i = 0; i < 6; i++) fifo_push(8'h50 + 8'(i));
    enable = 1; ready_in = 1;
    r0 = reads;
    for (int i = 0; i < 10 && !last_rd; i++) cycle();
    check("t3_started", last_rd, 1);
    enable = 0;
    cycle();
    check("t3_no_new_read", last_rd, 0);
    repeat (4) cycle();
    check("t3_busy", busy, 0);
    check("t3_valid", valid_out, 0);
    check("t3_delivered", pop_count, reads - r0);

    // Reset with two buffered words and one in flight.
    do_reset();
    for (int i = 0; i < 6; i++) fifo_push(8'hC0 + 8'(i));
    enable = 1; ready_in = 0;
    for (int i = 0; i < 12 && !(buf_q.size() == 2 && pending); i++) cycle();
    check("t4_setup", (buf_q.size() == 2 && pending), 1);
    reset = 1;
    cycle();
    reset = 0; enable = 0; ready_in = 1;
    repeat (3) cycle();
    check("t4_valid", valid_out, 0);
    check("t4_count", pop_count, 0);

    // Sticky error flag and clear priority.
    do_reset();
    fifo_error = 1;
    cycle();
    fifo_error = 0;
    repeat (2) cycle();
    check("t5_err_held", err_flag, 1);
    err_clear = 1;
    cycle();
    err_clear = 0;
    check("t5_err_cleared", err_flag, 0);
    err_clear = 1; fifo_error = 1;
    cycle();
    err_clear = 0; fifo_error = 0;
    check("t5_set_wins", err_flag, 1);

`ifdef FIFO_POP_CTRL_WATERMARK_EN
    do_reset();
    fifo_push(8'hE0);
    enable = 1; ready_in = 1;
    r0 = reads;
    repeat (5) cycle();
    check("wm_no_reads", reads - r0, 0);
    fifo_push(8'hE1); fifo_push(8'hE2); fifo_push(8'hE3);
    repeat (10) cycle();
    check("wm_burst", reads - r0, 4);
    check("wm_idle", busy, 0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom % 8) != 0;
      ready_in   = ($urandom % 4) != 0;
      reset      = ($urandom % 200) == 0;
      fifo_error = ($urandom % 50) == 0;
      err_clear  = ($urandom % 20) == 0;
      if (($urandom % 2) == 0 && fifo_q.size() < 16) fifo_push(8'($urandom));
      cycle();
    end
    reset = 0; enable = 0; ready_in = 1; fifo_error = 0; err_clear = 0;
    for (int i = 0; i < 20 && (buf_q.size() != 0 || pending); i++) cycle();
    check("drain_empty", buf_q.size() + pending, 0);
    check("drain_valid", valid_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_pop_ctrl.md
Name: fifo_pop_ctrl

Overview:
- Read-side controller for the parameterizable FIFOs in the switch datapath. It drains one FIFO via its `read` / `data_out_pop` / flag interface.
- Issues pop strobes only when the FIFO is non-empty and local space exists, so it never causes a FIFO underflow error.
- Captures popped words, which arrive one cycle after the read strobe, into a small skid buffer.
- Presents words downstream on a valid/ready handshake. Also keeps a popped-word count and a sticky error flag.

Parameters:
- DATA_SIZE, 8, data bus width in bits (matches the FIFO).
- BUF_DEPTH, 4, skid buffer entries; minimum 2; 4 gives one word per cycle sustained.
- COUNT_W, 16, width of pop_count.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- enable  in  1  permission to pop from the FIFO.
- fifo_empty  in  1  FIFO empty flag.
- fifo_almost_empty  in  1  FIFO almost-empty flag; used only with the optional feature.
- fifo_error  in  1  FIFO error flag.
- fifo_data  in  DATA_SIZE  FIFO popped-data register.
- fifo_read  out  1  pop strobe to the FIFO.
- data_out  out  DATA_SIZE  head of the skid buffer.
- valid_out  out  1  data_out valid.
- ready_in  in  1  downstream accept.
- pop_count  out  COUNT_W  words accepted downstream since reset.
- err_flag  out  1  sticky FIFO error seen.
- err_clear  in  1  clears err_flag.
- busy  out  1  state != IDLE, or an in-flight read, or buffer occupancy != 0.

Behaviour:
- Reset (clk edge with reset=1) clears:
  - state to IDLE, inflight, occ, and the buffer pointers;
  - data_out, valid_out, pop_count, err_flag, busy all to 0.
  - fifo_read is forced to 0 combinationally while reset=1.
  - A FIFO word in flight when reset hits is discarded.
- State machine, registered:
  - IDLE -> ACTIVE when enable=1.
  - ACTIVE -> IDLE when enable=0 and inflight=0.
  - The buffer keeps draining downstream in any state.
- fifo_read is combinational: state==ACTIVE && enable && !fifo_empty && (occ + inflight) < BUF_DEPTH.
  - There is no combinational path from ready_in to fifo_read.
- FIFO read latency is exactly 1 cycle.
  - inflight is a 1-bit register equal to the previous cycle's fifo_read.
  - When inflight=1, fifo_data is written into the buffer at that cycle's clock edge.
- Buffer: circular, with rd/wr pointers wrapping at BUF_DEPTH-1 -> 0.
  - occ is 0..BUF_DEPTH.
  - Simultaneous push and pop leave occ unchanged.
  - A push never happens at occ=BUF_DEPTH; this is guaranteed by the credit rule and is a bench assertion.
- Downstream handshake:
  - valid_out = (occ != 0).
  - data_out = buffer[rd_ptr].
  - Transfer happens when valid_out && ready_in.
  - data_out must stay stable while valid_out=1 and ready_in=0.
- pop_count increments on each downstream transfer and wraps modulo 2^COUNT_W.
- err_flag:
  - Set on any cycle with fifo_error=1; stays set.
  - Cleared by err_clear=1 unless fifo_error=1 in the same cycle, in which case set wins.
- The block does not use fifo_error to gate reads.

Optional Feature:
- Macro: FIFO_POP_CTRL_WATERMARK_EN (burst mode).
- With the macro defined:
  - IDLE -> ACTIVE requires enable && !fifo_empty && !fifo_almost_empty.
  - ACTIVE -> IDLE additionally occurs when fifo_empty=1 and inflight=0, which re-arms the block to wait for the next watermark.
- Without the macro:
  - fifo_almost_empty is ignored.
  - Transitions are exactly as in Behaviour.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33, enable=1, ready_in=1 -> fifo_read on 3 consecutive cycles; data_out 0x11,0x22,0x33 in order; pop_count=3; fifo_read never asserted while fifo_empty=1.
- FIFO holds 8 words, ready_in=0 -> exactly 4 fifo_read pulses (BUF_DEPTH=4), valid_out=1, data_out held at first word. Then ready_in=1 -> the remaining 4 words stream out, one per cycle after refill.
- enable dropped mid-stream with a read in flight -> no new fifo_read next cycle; the in-flight word is still captured and delivered; state returns to IDLE; busy=0 once the buffer drains.
- reset=1 for one cycle with occ=2 and inflight=1 -> valid_out=0, pop_count=0, and the late fifo_data word is never presented.
- fifo_error pulse -> err_flag=1 and held. err_clear with fifo_error=0 -> 0. err_clear and fifo_error together -> stays 1.
- With FIFO_POP_CTRL_WATERMARK_EN: 1 word in the FIFO (almost_empty=1), enable=1 -> no reads. After 3 more words are written -> burst of 4 reads, then back to IDLE on fifo_empty.
